fir_mac_sequencer: RTL

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

---
 rtl/fir_mac_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - sequential single-multiplier FIR MAC engine (define FIR_SAT_EN for output saturation)
module fir_mac_sequencer #(
   parameter int NTAP_MAX = 15,
   parameter int DW       = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          sample_valid,
   input  logic [DW-1:0] sample_in,
   output logic          sample_ready,
   input  logic [7:0]    taps,
   input  logic          coef_we,
   input  logic [3:0]    coef_addr,
   input  logic [DW-1:0] coef_wdata,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          busy
);

   localparam int AW = 2*DW + 4;
   localparam logic [7:0] NMAX = 8'(NTAP_MAX);
   localparam logic [3:0] LAST = 4'(NTAP_MAX - 1);

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t state, state_nxt;

   logic signed [DW-1:0]   sbuf  [NTAP_MAX];
   logic signed [DW-1:0]   coefs [NTAP_MAX];
   logic [3:0]             wptr;
   logic [3:0]             rptr;
   logic [7:0]             n;
   logic [7:0]             k;
   logic signed [AW-1:0]   acc;
   logic signed [2*DW-1:0] prod;
   logic signed [AW-1:0]   acc_next;
   logic [DW-1:0]          result;
   logic [DW-1:0]          out_data_r;
   logic [7:0]             taps_clamped;
   logic                   accept;
   logic                   last_mac;

   assign accept       = sample_valid && (state == IDLE);
   assign taps_clamped = (taps > NMAX) ? NMAX : taps;
   assign last_mac     = (k == n - 8'd1);

   // the one shared multiplier: rptr walks back from the newest sample while k walks the coefficients
   assign prod     = sbuf[rptr] * coefs[k[3:0]];
   assign acc_next = acc + AW'(prod);

`ifdef FIR_SAT_EN
   logic pos_ovf;
   logic neg_ovf;
   // any disagreement among the bits above acc[2*DW-2] means the sum left the 2*DW-bit signed range
   assign pos_ovf = !acc_next[AW-1] && (|acc_next[AW-2:2*DW-1]);
   assign neg_ovf =  acc_next[AW-1] && !(&acc_next[AW-2:2*DW-1]);
   assign result  = pos_ovf ? {1'b0, {(DW-1){1'b1}}} :
                    neg_ovf ? {1'b1, {(DW-1){1'b0}}} :
                    acc_next[2*DW-1:DW];
`else
   assign result = acc_next[2*DW-1:DW];
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic; taps of zero skip straight to DONE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = (taps_clamped == 8'd0) ? DONE : MAC;
         MAC:  if (last_mac) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // handshake and status outputs decoded from state
   always_comb begin
      sample_ready = (state == IDLE);
      busy         = (state == MAC) || (state == DONE);
      out_valid    = (state == DONE);
   end

   assign out_data = out_data_r;

   // datapath: coefficient writes, sample history, accumulation and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NTAP_MAX; i++) begin
            sbuf[i]  <= '0;
            coefs[i] <= '0;
         end
         wptr       <= '0;
         rptr       <= '0;
         n          <= '0;
         k          <= '0;
         acc        <= '0;
         out_data_r <= '0;
      end else begin
         // coefficient registers update at this edge, so the first MAC cycle already sees them
         if ((state == IDLE) && coef_we && ({4'd0, coef_addr} < NMAX))
            coefs[coef_addr] <= coef_wdata;
         if (accept) begin
            sbuf[wptr] <= sample_in;
            rptr       <= wptr;
            wptr       <= (wptr == LAST) ? 4'd0 : wptr + 4'd1;
            n          <= taps_clamped;
            k          <= '0;
            acc        <= '0;
            if (taps_clamped == 8'd0) out_data_r <= '0;
         end else if (state == MAC) begin
            acc  <= acc_next;
            k    <= k + 8'd1;
            rptr <= (rptr == 4'd0) ? LAST : rptr - 4'd1;
            if (last_mac) out_data_r <= result;
         end
      end
   end

endmodule
